// File: rtl/cmp_rs_unit_if.sv
// Handshake and broadcast bundle for the compare reservation station.
// master = instruction/update source and result sink, slave = cmp_rs_unit.
interface cmp_rs_unit_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int RS_ID_WIDTH  = 5,
  parameter int UPDATE_PORTS = 2
);
  logic                    input_valid;
  logic                    input_ready;
  logic [DATA_WIDTH-1:0]   op1;
  logic [DATA_WIDTH-1:0]   op2;
  logic                    op1_valid;
  logic                    op2_valid;
  logic                    xer_so_valid;
  logic [RS_ID_WIDTH-1:0]  op1_rs_id;
  logic [RS_ID_WIDTH-1:0]  op2_rs_id;
  logic [RS_ID_WIDTH-1:0]  xer_so_rs_id;
  logic                    xer_so;
  logic                    is_signed;
  logic                    l_bit;
  logic [2:0]              result_reg_addr_in;
  logic [RS_ID_WIDTH-1:0]  id_taken;

  logic [UPDATE_PORTS-1:0]                  update_op_valid;
  logic [UPDATE_PORTS-1:0][RS_ID_WIDTH-1:0] update_op_rs_id_in;
  logic [UPDATE_PORTS-1:0][DATA_WIDTH-1:0]  update_op_value_in;
  logic                                     update_xer_so_valid;
  logic [RS_ID_WIDTH-1:0]                   update_xer_so_rs_id_in;
  logic                                     update_xer_so_value_in;

  logic                    output_valid;
  logic                    output_ready;
  logic [RS_ID_WIDTH-1:0]  rs_id_out;
  logic [2:0]              result_reg_addr_out;
  logic [3:0]              result;

  modport master (
    output input_valid, op1, op2, op1_valid, op2_valid, xer_so_valid,
           op1_rs_id, op2_rs_id, xer_so_rs_id, xer_so, is_signed, l_bit,
           result_reg_addr_in, update_op_valid, update_op_rs_id_in,
           update_op_value_in, update_xer_so_valid, update_xer_so_rs_id_in,
           update_xer_so_value_in, output_ready,
    input  input_ready, id_taken, output_valid, rs_id_out,
           result_reg_addr_out, result
  );

  modport slave (
    input  input_valid, op1, op2, op1_valid, op2_valid, xer_so_valid,
           op1_rs_id, op2_rs_id, xer_so_rs_id, xer_so, is_signed, l_bit,
           result_reg_addr_in, update_op_valid, update_op_rs_id_in,
           update_op_value_in, update_xer_so_valid, update_xer_so_rs_id_in,
           update_xer_so_value_in, output_ready,
    output input_ready, id_taken, output_valid, rs_id_out,
           result_reg_addr_out, result
  );
endinterface

// File: rtl/cmp_rs_unit.sv
// Compare-unit reservation station with one-entry output register.
// Optional macro CMP_WAKEUP_BYPASS_EN lets an entry issue in the cycle its last operand is broadcast.
module cmp_rs_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int RS_DEPTH     = 8,
  parameter int RS_OFFSET    = 0,
  parameter int RS_ID_WIDTH  = 5,
  parameter int UPDATE_PORTS = 2
) (
  input logic           clk,
  input logic           rst,
  cmp_rs_unit_if.slave  bus
);
  localparam int IW = $clog2(RS_DEPTH);

  typedef struct packed {
    logic                   busy;
    logic [DATA_WIDTH-1:0]  op1;
    logic                   op1_vld;
    logic [RS_ID_WIDTH-1:0] op1_tag;
    logic [DATA_WIDTH-1:0]  op2;
    logic                   op2_vld;
    logic [RS_ID_WIDTH-1:0] op2_tag;
    logic                   so;
    logic                   so_vld;
    logic [RS_ID_WIDTH-1:0] so_tag;
    logic                   is_signed;
    logic                   l_bit;
    logic [2:0]             addr;
  } entry_t;

  entry_t                  ent_q [RS_DEPTH];
  entry_t                  ent_d [RS_DEPTH];
  entry_t                  ent_w [RS_DEPTH];
  entry_t                  ent_n;
  logic [RS_DEPTH-1:0]     rdy;
  logic [RS_DEPTH-1:0]     free;
  logic [IW-1:0]           alloc_idx;
  logic [IW-1:0]           iss_idx;
  logic                    iss_any;
  logic                    iss_en;
  logic                    acc;
  logic [2:0]              cmp_flags;

  logic                    out_valid_q, out_valid_d;
  logic [RS_ID_WIDTH-1:0]  out_id_q, out_id_d;
  logic [2:0]              out_addr_q, out_addr_d;
  logic [3:0]              out_res_q, out_res_d;

  // Lower-numbered channel is applied last so it wins on a multi-match.
  function automatic logic [DATA_WIDTH:0] wake_op(
    input logic                                     vld,
    input logic [RS_ID_WIDTH-1:0]                   tag,
    input logic [DATA_WIDTH-1:0]                    val,
    input logic [UPDATE_PORTS-1:0]                  uv,
    input logic [UPDATE_PORTS-1:0][RS_ID_WIDTH-1:0] ut,
    input logic [UPDATE_PORTS-1:0][DATA_WIDTH-1:0]  ud
  );
    logic [DATA_WIDTH:0] r;
    r = {vld, val};
    if (!vld) begin
      for (int c = UPDATE_PORTS - 1; c >= 0; c--) begin
        if (uv[c] && ut[c] == tag) r = {1'b1, ud[c]};
      end
    end
    return r;
  endfunction

  function automatic logic [1:0] wake_so(
    input logic                   vld,
    input logic [RS_ID_WIDTH-1:0] tag,
    input logic                   val,
    input logic                   uv,
    input logic [RS_ID_WIDTH-1:0] ut,
    input logic                   ud
  );
    logic [1:0] r;
    r = {vld, val};
    if (!vld && uv && ut == tag) r = {1'b1, ud};
    return r;
  endfunction

  // Both operands are widened to 65 bits so one signed compare covers every mode.
  function automatic logic [2:0] cmp3(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic                  sgn,
    input logic                  lb
  );
    logic [63:0]        a64, b64;
    logic signed [64:0] ax, bx;
    logic               lt, eq;
    a64 = 64'(a);
    b64 = 64'(b);
    if (lb && DATA_WIDTH == 64) begin
      ax = {sgn & a64[63], a64};
      bx = {sgn & b64[63], b64};
    end else begin
      ax = {{33{sgn & a64[31]}}, a64[31:0]};
      bx = {{33{sgn & b64[31]}}, b64[31:0]};
    end
    lt = ax < bx;
    eq = ax == bx;
    return {lt, ~lt & ~eq, eq};
  endfunction

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_w[i] = ent_q[i];
      {ent_w[i].op1_vld, ent_w[i].op1} = wake_op(ent_q[i].op1_vld, ent_q[i].op1_tag, ent_q[i].op1,
        bus.update_op_valid, bus.update_op_rs_id_in, bus.update_op_value_in);
      {ent_w[i].op2_vld, ent_w[i].op2} = wake_op(ent_q[i].op2_vld, ent_q[i].op2_tag, ent_q[i].op2,
        bus.update_op_valid, bus.update_op_rs_id_in, bus.update_op_value_in);
      {ent_w[i].so_vld, ent_w[i].so} = wake_so(ent_q[i].so_vld, ent_q[i].so_tag, ent_q[i].so,
        bus.update_xer_so_valid, bus.update_xer_so_rs_id_in, bus.update_xer_so_value_in);
`ifdef CMP_WAKEUP_BYPASS_EN
      rdy[i] = ent_w[i].busy & ent_w[i].op1_vld & ent_w[i].op2_vld & ent_w[i].so_vld;
`else
      rdy[i] = ent_q[i].busy & ent_q[i].op1_vld & ent_q[i].op2_vld & ent_q[i].so_vld;
`endif
      free[i] = ~ent_q[i].busy;
    end

    alloc_idx = '0;
    iss_idx   = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (free[i]) alloc_idx = IW'(i);
      if (rdy[i])  iss_idx   = IW'(i);
    end
    iss_any = |rdy;
    iss_en  = iss_any & (~out_valid_q | bus.output_ready);
    acc     = bus.input_valid & (|free);

    ent_n           = '0;
    ent_n.busy      = 1'b1;
    ent_n.op1_tag   = bus.op1_rs_id;
    ent_n.op2_tag   = bus.op2_rs_id;
    ent_n.so_tag    = bus.xer_so_rs_id;
    ent_n.is_signed = bus.is_signed;
    ent_n.l_bit     = bus.l_bit;
    ent_n.addr      = bus.result_reg_addr_in;
    {ent_n.op1_vld, ent_n.op1} = wake_op(bus.op1_valid, bus.op1_rs_id, bus.op1,
      bus.update_op_valid, bus.update_op_rs_id_in, bus.update_op_value_in);
    {ent_n.op2_vld, ent_n.op2} = wake_op(bus.op2_valid, bus.op2_rs_id, bus.op2,
      bus.update_op_valid, bus.update_op_rs_id_in, bus.update_op_value_in);
    {ent_n.so_vld, ent_n.so} = wake_so(bus.xer_so_valid, bus.xer_so_rs_id, bus.xer_so,
      bus.update_xer_so_valid, bus.update_xer_so_rs_id_in, bus.update_xer_so_value_in);

    for (int i = 0; i < RS_DEPTH; i++) ent_d[i] = ent_w[i];
    if (iss_en) ent_d[iss_idx].busy = 1'b0;
    if (acc)    ent_d[alloc_idx]    = ent_n;

    cmp_flags = cmp3(ent_w[iss_idx].op1, ent_w[iss_idx].op2,
                     ent_w[iss_idx].is_signed, ent_w[iss_idx].l_bit);

    out_valid_d = out_valid_q & ~bus.output_ready;
    out_id_d    = out_id_q;
    out_addr_d  = out_addr_q;
    out_res_d   = out_res_q;
    if (iss_en) begin
      out_valid_d = 1'b1;
      out_id_d    = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(iss_idx);
      out_addr_d  = ent_w[iss_idx].addr;
      out_res_d   = {cmp_flags, ent_w[iss_idx].so};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i].busy <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_addr_q  <= '0;
      out_res_q   <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_addr_q  <= out_addr_d;
      out_res_q   <= out_res_d;
    end
  end

  assign bus.input_ready         = |free;
  assign bus.id_taken            = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(alloc_idx);
  assign bus.output_valid        = out_valid_q;
  assign bus.rs_id_out           = out_id_q;
  assign bus.result_reg_addr_out = out_addr_q;
  assign bus.result              = out_res_q;
endmodule

// File: doc/cmp_rs_unit.md
CMP_RS_UNIT -- requirements
Module: cmp_rs_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand width, legal values 32 or 64.
REQ-002 Parameter RS_DEPTH, default 8: number of reservation-station entries, range 2..16.
REQ-003 Parameter RS_OFFSET, default 0: ID of entry 0; entry i has ID RS_OFFSET+i.
REQ-004 Parameter RS_ID_WIDTH, default 5: tag width; RS_OFFSET+RS_DEPTH-1 SHALL fit.
REQ-005 Parameter UPDATE_PORTS, default 2: number of GPR result broadcast channels, range 1..4.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  synchronous, active-low reset.
REQ-008 input_valid/input_ready  in/out  1/1  new-instruction handshake.
REQ-009 op1, op2  in  DATA_WIDTH each  operand values, op2 holds an already-extended immediate when applicable.
REQ-010 op1_valid, op2_valid, xer_so_valid  in  1 each  operand present; otherwise wait on the matching *_rs_id tag (RS_ID_WIDTH each).
REQ-011 xer_so  in  1  summary-overflow value.
REQ-012 is_signed, l_bit  in  1 each  signed compare; 64-bit compare (ignored, treated as 0, when DATA_WIDTH=32).
REQ-013 result_reg_addr_in  in  3  destination CR field.
REQ-014 id_taken  out  RS_ID_WIDTH  ID of the entry allocated this cycle.
REQ-015 update_op_valid, update_op_rs_id_in, update_op_value_in  in  UPDATE_PORTS x (1, RS_ID_WIDTH, DATA_WIDTH)  GPR broadcast channels.
REQ-016 update_xer_so_valid, update_xer_so_rs_id_in, update_xer_so_value_in  in  1, RS_ID_WIDTH, 1  SO broadcast.
REQ-017 output_valid/output_ready  out/in  1/1  result handshake; rs_id_out RS_ID_WIDTH, result_reg_addr_out 3, result 4 (LT,GT,EQ,SO).

Function
REQ-018 input_ready SHALL be 1 iff at least one entry is free; it SHALL NOT depend on a same-cycle issue.
REQ-019 On input_valid&input_ready the lowest-index free entry SHALL be written and id_taken SHALL equal its ID combinationally in that cycle.
REQ-020 Each waiting operand SHALL capture the value of any update channel whose valid is set and whose tag matches; if several channels match, the lowest-numbered channel wins.
REQ-021 An incoming operand whose tag matches an update in the same cycle SHALL capture the update value, not wait.
REQ-022 An entry is ready when op1, op2 and SO are all captured; the lowest-index ready entry SHALL issue when the output stage is empty or drains this cycle, and is freed on issue.
REQ-023 Compare: l_bit=0 compares low 32 bits, sign-extended if is_signed else zero-extended; l_bit=1 compares full 64 bits.
REQ-024 Exactly one of LT/GT/EQ SHALL be set; SO bit = captured xer_so.
REQ-025 The output stage is one register; output_valid and all output payload SHALL hold stable until output_ready.
REQ-026 Latency: instruction accepted with all operands valid at cycle N -> issue N+1 -> output_valid N+2, with full throughput of one result per cycle while output_ready=1.
REQ-027 An entry freed by issue SHALL be allocatable no earlier than the following cycle.

Reset
REQ-028 While rst=0 at a clock edge, all entries SHALL become free and output_valid SHALL become 0; input_ready SHALL be 1 and id_taken RS_OFFSET in the first cycle after reset.
REQ-029 Reset mid-operation SHALL discard all pending and output-held instructions without emitting them.

Configuration
REQ-030 Macro CMP_WAKEUP_BYPASS_EN: when defined, an entry whose last missing operand arrives on an update channel at cycle M SHALL issue at M using the broadcast value (output_valid M+1).
REQ-031 Without CMP_WAKEUP_BYPASS_EN, that entry SHALL issue at M+1 (output_valid M+2); results SHALL be identical in both builds.

Verification
REQ-032 op1=5, op2=0xFFFFFFFB (-5), is_signed=1, so=0 -> result=0100 (GT), output_valid at N+2.
REQ-033 Same operands, is_signed=0 -> result=1000 (LT).
REQ-034 DATA_WIDTH=64, op1=0x1_00000000, op2=0, l_bit=0 -> 0010 (EQ); l_bit=1 -> 0100 (GT).
REQ-035 Fill all RS_DEPTH entries with op1 waiting on tag 3 -> input_ready=0; broadcast tag 3 value 7 on channel 1 -> all issue lowest index first, one per cycle, in bypass build first output at M+1, else M+2.
REQ-036 Hold output_ready=0 for 5 cycles with two ready entries -> output payload stable, second entry not issued; release -> both delivered back-to-back.
REQ-037 Assert rst=0 with 3 pending entries and output_valid=1 -> next cycle output_valid=0, input_ready=1, id_taken=RS_OFFSET.
